io_ctrl: RTL and testbench

IO_CTRL -- requirements
Module: io_ctrl

---
 rtl/io_ctrl_pkg.sv | 33 +++
 rtl/io_debounce.sv | 41 ++++
 rtl/io_ctrl.sv | 135 +++++++++++++
 tb/tb_io_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_ctrl_pkg.sv
// Shared processor constants for the memory-mapped I/O page.
// Holds register offsets, KEDGE bit indices and the miss pattern.
package io_ctrl_pkg;

    localparam logic [11:0] IO_PAGE  = 12'hFFF;

    localparam logic [15:0] IO_KDATA = 16'hFFF0;
    localparam logic [15:0] IO_SDATA = 16'hFFF2;
    localparam logic [15:0] IO_KEDGE = 16'hFFF4;
    localparam logic [15:0] IO_TIMER = 16'hFFF6;
    localparam logic [15:0] IO_HEX   = 16'hFFF8;
    localparam logic [15:0] IO_LEDR  = 16'hFFFA;
    localparam logic [15:0] IO_LEDG  = 16'hFFFC;
    localparam logic [15:0] IO_NONE  = 16'hFFFE;

    localparam logic [15:0] IO_MISS  = 16'hDEAD;

    localparam int KE_KEYS  = 4;
    localparam int KE_TIMER = 4;

    // Register slot selected by ADDR[3:1]
    typedef enum logic [2:0] {
        R_KDATA = 3'd0,
        R_SDATA = 3'd1,
        R_KEDGE = 3'd2,
        R_TIMER = 3'd3,
        R_HEX   = 3'd4,
        R_LEDR  = 3'd5,
        R_LEDG  = 3'd6,
        R_NONE  = 3'd7
    } io_reg_e;

endpackage

// File: rtl/io_debounce.sv
// One input bit: 2-flop synchronizer followed by a stability debouncer.
// Ports: clk, rst_n (async low), raw (async input), db (debounced level).
module io_debounce #(
    parameter int DB_CYCLES = 500000,
    parameter bit INV       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

    logic [1:0]    sync;
    logic          cur;
    logic [CW-1:0] cnt;

    // Polarity fix-up sits after the synchronizer
    assign cur = sync[1] ^ INV;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (cur == db) begin
                cnt <= '0;
            end else if (cnt == CMAX) begin
                db  <= cur;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped I/O page: keys, switches, event flags, timer, displays.
// Ports: CLK, RESET_N, ADDR/WE/DIN/DOUT/SEL bus, KEY, SW, HEX, LEDR, LEDG.
module io_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int DBITS       = 16,
    parameter int DB_CYCLES   = 500000,
    parameter int TICK_CYCLES = 50000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [DBITS-1:0] ADDR,
    input  logic             WE,
    input  logic [DBITS-1:0] DIN,
    output logic [DBITS-1:0] DOUT,
    output logic             SEL,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [15:0]      HEX,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);

    io_reg_e          rsel;
    logic             wr;
    logic             wr_kedge;
    logic             wr_timer;
    logic [3:0]       kdata;
    logic [3:0]       kdata_q;
    logic [9:0]       sdata;
    logic [4:0]       kedge;
    logic [4:0]       kedge_n;
    logic [4:0]       clr;
    logic [DBITS-1:0] timer;
    logic [PW-1:0]    presc;
    logic             wrap;
    logic             expire;
    logic             unused_addr;

    assign unused_addr = ADDR[0];

    assign SEL      = (ADDR[15:4] == IO_PAGE);
    assign rsel     = io_reg_e'(ADDR[3:1]);
    assign wr       = WE && SEL;
    assign wr_kedge = wr && (rsel == R_KEDGE);
    assign wr_timer = wr && (rsel == R_TIMER);

    for (genvar i = 0; i < KE_KEYS; i++) begin : g_key
        io_debounce #(
            .DB_CYCLES(DB_CYCLES),
            .INV      (1'b1)
        ) u_db (
            .clk  (CLK),
            .rst_n(RESET_N),
            .raw  (KEY[i]),
            .db   (kdata[i])
        );
    end

    for (genvar i = 0; i < 10; i++) begin : g_sw
        io_debounce #(
            .DB_CYCLES(DB_CYCLES),
            .INV      (1'b0)
        ) u_db (
            .clk  (CLK),
            .rst_n(RESET_N),
            .raw  (SW[i]),
            .db   (sdata[i])
        );
    end

    assign wrap = (presc == PMAX);

    // A load in the same cycle suppresses the 1->0 transition
    assign expire = wrap && (timer == DBITS'(1)) && !wr_timer;

    // Sets are OR-ed in after the clear so a colliding set survives
    assign clr     = wr_kedge ? DIN[4:0] : 5'b0;
    assign kedge_n = (kedge & ~clr) | {expire, kdata & ~kdata_q};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            kdata_q <= '0;
            kedge   <= '0;
            timer   <= '0;
            presc   <= '0;
            HEX     <= '0;
            LEDR    <= '0;
            LEDG    <= '0;
        end else begin
            kdata_q <= kdata;
            kedge   <= kedge_n;
            if (wr_timer) begin
                timer <= DIN;
                presc <= '0;
            end else begin
                presc <= wrap ? '0 : presc + 1'b1;
                if (wrap && (timer != '0)) begin
                    timer <= timer - 1'b1;
                end
            end
            if (wr && (rsel == R_HEX)) begin
                HEX <= DIN[15:0];
            end
            if (wr && (rsel == R_LEDR)) begin
                LEDR <= DIN[9:0];
            end
            if (wr && (rsel == R_LEDG)) begin
                LEDG <= DIN[7:0];
            end
        end
    end

    always_comb begin
        DOUT = '0;
        if (!SEL) begin
            DOUT = DBITS'(IO_MISS);
        end else begin
            unique case (rsel)
                R_KDATA: DOUT = DBITS'(kdata);
                R_SDATA: DOUT = DBITS'(sdata);
                R_KEDGE: DOUT = DBITS'(kedge);
                R_TIMER: DOUT = timer;
                R_HEX:   DOUT = DBITS'(HEX);
                R_LEDR:  DOUT = DBITS'(LEDR);
                R_LEDG:  DOUT = DBITS'(LEDG);
                R_NONE:  DOUT = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl: vector table, directed corners,
// and random bus traffic against an arithmetic reference model.
module tb_io_ctrl;
    import io_ctrl_pkg::*;

    localparam int DB = 4;
    localparam int TK = 3;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] ADDR;
    logic        WE;
    logic [15:0] DIN;
    logic [15:0] DOUT;
    logic        SEL;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [15:0] HEX;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    io_ctrl #(
        .DBITS      (16),
        .DB_CYCLES  (DB),
        .TICK_CYCLES(TK)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .ADDR   (ADDR),
        .WE     (WE),
        .DIN    (DIN),
        .DOUT   (DOUT),
        .SEL    (SEL),
        .KEY    (KEY),
        .SW     (SW),
        .HEX    (HEX),
        .LEDR   (LEDR),
        .LEDG   (LEDG)
    );

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] din;
        logic [15:0] dout;
        logic        sel;
    } vec_t;

    vec_t tbl[13];

    // reference model state for the random phase
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    logic        m_k4;
    int          now;
    int          load_cyc;
    int          load_val;

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        DIN  = d;
        WE   = 1'b1;
        tick(1);
        WE   = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a,
                          input logic [15:0] exp);
        ADDR = a;
        #1;
        chk(name, DOUT, exp);
    endtask

    function automatic logic [15:0] tval(input int t);
        int d;
        d = (t - load_cyc) / TK;
        return (load_val > d) ? 16'(load_val - d) : 16'h0;
    endfunction

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        logic [15:0] r;
        r = 16'h0;
        if (a[15:4] != IO_PAGE) begin
            r = IO_MISS;
        end else begin
            case (a[3:1])
                3'd1: r = 16'h03FF;
                3'd2: r = {11'b0, m_k4, 4'b0};
                3'd3: r = tval(now);
                3'd4: r = m_hex;
                3'd5: r = {6'b0, m_ledr};
                3'd6: r = {8'b0, m_ledg};
                default: r = 16'h0;
            endcase
        end
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] d;
        logic        w;
        logic        s;
        logic        tw;
        logic        ex;
        int          op;

        RESET_N = 1'b0;
        KEY  = 4'hF;
        SW   = 10'h3FF;
        WE   = 1'b0;
        ADDR = 16'h0;
        DIN  = 16'h0;

        // reset state
        tick(3);
        chk("rst_hex", HEX, 16'h0);
        chk("rst_ledr", {6'b0, LEDR}, 16'h0);
        chk("rst_ledg", {8'b0, LEDG}, 16'h0);
        rd_chk("rst_kedge", IO_KEDGE, 16'h0);
        rd_chk("rst_timer", IO_TIMER, 16'h0);
        rd_chk("rst_sdata", IO_SDATA, 16'h0);
        RESET_N = 1'b1;
        tick(5);
        rd_chk("sdata_early", IO_SDATA, 16'h0);
        tick(1);
        rd_chk("sdata_rel6", IO_SDATA, 16'h03FF);
        rd_chk("kdata_rel", IO_KDATA, 16'h0);
        rd_chk("kedge_rel", IO_KEDGE, 16'h0);

        // register writes and decode
        tbl[0]  = '{16'hFFF8, 1'b1, 16'hBEEF, 16'h0000, 1'b1};
        tbl[1]  = '{16'hFFF8, 1'b0, 16'h0000, 16'hBEEF, 1'b1};
        tbl[2]  = '{16'hFFFA, 1'b1, 16'hFFFF, 16'h0000, 1'b1};
        tbl[3]  = '{16'hFFFA, 1'b0, 16'h0000, 16'h03FF, 1'b1};
        tbl[4]  = '{16'hFFFC, 1'b1, 16'hABCD, 16'h0000, 1'b1};
        tbl[5]  = '{16'hFFFC, 1'b0, 16'h0000, 16'h00CD, 1'b1};
        tbl[6]  = '{16'h1000, 1'b1, 16'h1234, 16'hDEAD, 1'b0};
        tbl[7]  = '{16'h1FF8, 1'b1, 16'h0000, 16'hDEAD, 1'b0};
        tbl[8]  = '{16'hFFF8, 1'b0, 16'h0000, 16'hBEEF, 1'b1};
        tbl[9]  = '{16'hFFFE, 1'b1, 16'h5555, 16'h0000, 1'b1};
        tbl[10] = '{16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tbl[11] = '{16'hFFF9, 1'b0, 16'h0000, 16'hBEEF, 1'b1};
        tbl[12] = '{16'hFFFB, 1'b0, 16'h0000, 16'h03FF, 1'b1};
        for (int i = 0; i < 13; i++) begin
            ADDR = tbl[i].addr;
            WE   = tbl[i].we;
            DIN  = tbl[i].din;
            #1;
            chk($sformatf("tbl%0d_dout", i), DOUT, tbl[i].dout);
            chk($sformatf("tbl%0d_sel", i), {15'b0, SEL},
                {15'b0, tbl[i].sel});
            tick(1);
            WE = 1'b0;
        end
        chk("hex_port", HEX, 16'hBEEF);
        chk("ledr_port", {6'b0, LEDR}, 16'h03FF);
        chk("ledg_port", {8'b0, LEDG}, 16'h00CD);

        // 3-clock glitch never reaches KDATA
        KEY = 4'hE;
        tick(3);
        KEY = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            rd_chk("glitch_kdata", IO_KDATA, 16'h0);
            rd_chk("glitch_kedge", IO_KEDGE, 16'h0);
        end

        // 10-clock press
        KEY = 4'hE;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            rd_chk($sformatf("press_kdata_c%0d", i), IO_KDATA,
                   (i >= 6) ? 16'h1 : 16'h0);
            rd_chk($sformatf("press_kedge_c%0d", i), IO_KEDGE,
                   (i >= 7) ? 16'h1 : 16'h0);
        end
        KEY = 4'hF;
        tick(8);
        rd_chk("release_kdata", IO_KDATA, 16'h0);
        rd_chk("release_kedge", IO_KEDGE, 16'h1);

        // W1C and set/clear collision
        KEY = 4'hD;
        tick(8);
        KEY = 4'hF;
        tick(8);
        rd_chk("kedge_two", IO_KEDGE, 16'h3);
        wr(IO_KEDGE, 16'h1);
        rd_chk("w1c_bit0", IO_KEDGE, 16'h2);
        KEY = 4'hE;
        tick(6);
        rd_chk("pre_coll_kdata", IO_KDATA, 16'h1);
        rd_chk("pre_coll_kedge", IO_KEDGE, 16'h2);
        wr(IO_KEDGE, 16'h1);
        rd_chk("coll_set_wins", IO_KEDGE, 16'h3);
        KEY = 4'hF;
        tick(8);
        wr(IO_KEDGE, 16'h001F);
        rd_chk("w1c_all", IO_KEDGE, 16'h0);

        // timer countdown and expiry
        wr(IO_TIMER, 16'h2);
        rd_chk("tmr_load", IO_TIMER, 16'h2);
        tick(2);
        rd_chk("tmr_w2", IO_TIMER, 16'h2);
        tick(1);
        rd_chk("tmr_w3", IO_TIMER, 16'h1);
        rd_chk("tmr_w3_kedge", IO_KEDGE, 16'h0);
        tick(2);
        rd_chk("tmr_w5_kedge", IO_KEDGE, 16'h0);
        tick(1);
        rd_chk("tmr_w6", IO_TIMER, 16'h0);
        rd_chk("tmr_expire", IO_KEDGE, 16'h10);
        tick(6);
        rd_chk("tmr_hold0", IO_TIMER, 16'h0);
        wr(IO_KEDGE, 16'h001F);
        wr(IO_TIMER, 16'h0);
        tick(10);
        rd_chk("load0_kedge", IO_KEDGE, 16'h0);

        // random bus traffic vs model
        wr(IO_KEDGE, 16'h001F);
        wr(IO_TIMER, 16'h0);
        m_hex = 16'hBEEF;
        m_ledr = 10'h3FF;
        m_ledg = 8'hCD;
        m_k4 = 1'b0;
        now = 0;
        load_cyc = 0;
        load_val = 0;
        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 11);
            w = 1'b1;
            d = 16'($urandom);
            case (op)
                0: a = IO_HEX;
                1: a = IO_LEDR;
                2: a = IO_LEDG;
                3: begin
                    a = IO_TIMER;
                    d = 16'($urandom_range(0, 4));
                end
                4: a = IO_KEDGE;
                5: a = {1'b0, 15'($urandom)};
                6: begin
                    d = 16'($urandom_range(0, 2));
                    a = (d == 0) ? IO_KDATA :
                        (d == 1) ? IO_SDATA : IO_NONE;
                    d = 16'($urandom);
                end
                default: begin
                    a = {12'hFFF, 4'($urandom)};
                    w = 1'b0;
                end
            endcase
            ADDR = a;
            WE = w;
            DIN = d;
            #1;
            chk("rand_dout", DOUT, model_rd(a));
            chk("rand_hex", HEX, m_hex);
            chk("rand_ledr", {6'b0, LEDR}, {6'b0, m_ledr});
            chk("rand_ledg", {8'b0, LEDG}, {8'b0, m_ledg});
            tick(1);
            WE = 1'b0;
            s = (a[15:4] == IO_PAGE);
            tw = w && s && (a[3:1] == 3'd3);
            ex = (load_val > 0) &&
                 (now + 1 == load_cyc + load_val * TK) && !tw;
            m_k4 = (m_k4 && !(w && s && (a[3:1] == 3'd2) && d[4])) || ex;
            if (tw) begin
                load_cyc = now + 1;
                load_val = int'(d);
            end
            if (w && s && (a[3:1] == 3'd4)) m_hex = d;
            if (w && s && (a[3:1] == 3'd5)) m_ledr = d[9:0];
            if (w && s && (a[3:1] == 3'd6)) m_ledg = d[7:0];
            now++;
        end

        // reset mid-countdown leaves no residue
        wr(IO_KEDGE, 16'h001F);
        wr(IO_TIMER, 16'h5);
        tick(4);
        RESET_N = 1'b0;
        #1;
        rd_chk("midrst_timer", IO_TIMER, 16'h0);
        rd_chk("midrst_kedge", IO_KEDGE, 16'h0);
        chk("midrst_hex", HEX, 16'h0);
        tick(2);
        RESET_N = 1'b1;
        tick(25);
        rd_chk("postrst_timer", IO_TIMER, 16'h0);
        rd_chk("postrst_kedge", IO_KEDGE, 16'h0);
        rd_chk("postrst_sdata", IO_SDATA, 16'h03FF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
